icache_ctrl: RTL and testbench



---
 rtl/icache_ctrl_pkg.sv | 19 +
 rtl/icache_ctrl_mem.sv | 32 +++
 rtl/icache_ctrl.sv | 146 ++++++++++++++
 tb/tb_icache_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped instruction cache controller.
package icache_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } BUS_COMMAND;

  // Tag field is XLEN wide so the struct is independent of NUM_LINES; unused upper bits stay zero.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [63:0]     data;
  } ICACHE_LINE;

endpackage

// File: rtl/icache_ctrl_mem.sv
// icache_mem: NUM_LINES-entry line array, one combinational read port, one synchronous write port.
module icache_mem
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output ICACHE_LINE          rd_line,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  ICACHE_LINE          wr_line
);

  ICACHE_LINE lines_r [NUM_LINES];

  // Line storage: cleared on reset, written on a fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lines_r[i] <= '0;
      end
    end else if (wr_en) begin
      lines_r[wr_idx] <= wr_line;
    end
  end

  assign rd_line = lines_r[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with a single outstanding tagged miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      proc2Icache_addr,
  input  logic                 proc2Icache_req,
  output logic [63:0]          Icache_data_out,
  output logic                 Icache_valid_out,
  output logic [1:0]           proc2Imem_command,
  output logic [XLEN-1:0]      proc2Imem_addr,
  input  logic [MEM_TAG_W-1:0] Imem2proc_response,
  input  logic [63:0]          Imem2proc_data,
  input  logic [MEM_TAG_W-1:0] Imem2proc_tag
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]           state_r;
  logic [XLEN-1:0]      miss_addr_r;
  logic [MEM_TAG_W-1:0] mem_tag_r;

  logic [XLEN-1:0]     blk_addr_s;
  logic [XLEN-1:0]     line_tag_s;
  logic [IDX_BITS-1:0] idx_s;
  ICACHE_LINE          rd_line_s;
  ICACHE_LINE          wr_line_s;
  logic                hit_s;
  logic                miss_req_s;
  logic                fill_s;
  logic                bypass_s;

  assign blk_addr_s = {proc2Icache_addr[XLEN-1:3], 3'b000};
  assign idx_s      = proc2Icache_addr[IDX_BITS+2:3];
  assign line_tag_s = proc2Icache_addr >> (IDX_BITS + 3);

  icache_mem #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (idx_s),
    .rd_line (rd_line_s),
    .wr_en   (fill_s),
    .wr_idx  (miss_addr_r[IDX_BITS+2:3]),
    .wr_line (wr_line_s)
  );

  // Lookup, fill detection and fill-line assembly.
  always_comb begin
    hit_s           = proc2Icache_req && rd_line_s.valid && (rd_line_s.tag == line_tag_s);
    miss_req_s      = proc2Icache_req && !hit_s;
    // A zero tag never matches: mem_tag_r is zero outside WAIT, and the explicit check guards WAIT.
    fill_s          = (state_r == S_WAIT) && (Imem2proc_tag != '0) && (Imem2proc_tag == mem_tag_r);
    bypass_s        = fill_s && proc2Icache_req && (blk_addr_s == miss_addr_r);
    wr_line_s.valid = 1'b1;
    wr_line_s.tag   = miss_addr_r >> (IDX_BITS + 3);
    wr_line_s.data  = Imem2proc_data;
  end

  // Fetch-side and memory-side outputs.
  always_comb begin
    Icache_valid_out = hit_s || bypass_s;
    if (bypass_s) begin
      Icache_data_out = Imem2proc_data;
    end else if (hit_s) begin
      Icache_data_out = rd_line_s.data;
    end else begin
      Icache_data_out = 64'd0;
    end
    if (state_r == S_REQ) begin
      proc2Imem_command = BUS_LOAD;
      proc2Imem_addr    = miss_addr_r;
    end else begin
      proc2Imem_command = BUS_NONE;
      proc2Imem_addr    = {XLEN{1'b0}};
    end
  end

  // Miss FSM: IDLE -> REQ (retarget until accepted) -> WAIT (until tagged data returns).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      miss_addr_r <= {XLEN{1'b0}};
      mem_tag_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (miss_req_s) begin
            miss_addr_r <= blk_addr_s;
            state_r     <= S_REQ;
          end
        end
        S_REQ: begin
          if (Imem2proc_response != '0) begin
            mem_tag_r <= Imem2proc_response;
            state_r   <= S_WAIT;
          end else if (proc2Icache_req && (blk_addr_s != miss_addr_r)) begin
            miss_addr_r <= blk_addr_s;
          end
        end
        S_WAIT: begin
          if (fill_s) begin
            mem_tag_r <= '0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          mem_tag_r <= '0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit and miss-issue event counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_count <= hit_count + 32'd1;
      end
      if ((state_r == S_IDLE) && miss_req_s) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] proc2Icache_addr = 32'd0;
  logic        proc2Icache_req = 1'b0;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic [1:0]  proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response = 4'd0;
  logic [63:0] Imem2proc_data = 64'd0;
  logic [3:0]  Imem2proc_tag = 4'd0;

  icache_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .proc2Icache_req    (proc2Icache_req),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst;
    logic [31:0] a;
    logic        r;
    logic [3:0]  resp;
    logic [3:0]  rt;
    logic [63:0] rd;
  } cyc_t;

  // Reference model: which block each index holds, plus the single outstanding miss.
  bit          mv [32];
  logic [31:0] mblk [32];
  logic [63:0] mdat [32];
  bit          pend = 1'b0;
  bit          acc = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [3:0]  ptag = 4'd0;
  logic [31:0] m_blk;
  bit          m_rhit, m_fill, m_byp;
  logic [98:0] obs, expv;

  function automatic cyc_t cy(logic [31:0] a, logic r, logic [3:0] resp, logic [3:0] rt,
                              logic [63:0] rd, logic rst = 1'b0);
    cyc_t c;
    c.rst = rst; c.a = a; c.r = r; c.resp = resp; c.rt = rt; c.rd = rd;
    return c;
  endfunction

  function automatic logic [63:0] memdata(logic [31:0] a);
    return {a ^ 32'h5A5AF00D, ~a};
  endfunction

  function automatic void model_eval();
    logic [4:0] ix;
    m_blk  = proc2Icache_addr & 32'hFFFF_FFF8;
    ix     = m_blk[7:3];
    m_rhit = proc2Icache_req && mv[ix] && (mblk[ix] == m_blk);
    m_fill = pend && acc && (Imem2proc_tag != 4'd0) && (Imem2proc_tag == ptag);
    m_byp  = m_fill && proc2Icache_req && (m_blk == paddr);
  endfunction

  task automatic drive(input cyc_t c);
    logic        ev;
    logic [63:0] ed;
    logic [1:0]  ec;
    logic [31:0] ea;
    reset = c.rst; proc2Icache_addr = c.a; proc2Icache_req = c.r;
    Imem2proc_response = c.resp; Imem2proc_tag = c.rt; Imem2proc_data = c.rd;
    #1;
    model_eval();
    ev = m_rhit || m_byp;
    ed = m_byp ? c.rd : (m_rhit ? mdat[m_blk[7:3]] : 64'd0);
    ec = (pend && !acc) ? 2'd1 : 2'd0;
    ea = (pend && !acc) ? paddr : 32'd0;
    expv = {ev, ed, ec, ea};
    obs  = {Icache_valid_out, Icache_data_out, proc2Imem_command, proc2Imem_addr};
  endtask

  task automatic tick();
    logic [4:0] pi;
    if (reset) begin
      for (int i = 0; i < 32; i++) mv[i] = 1'b0;
      pend = 1'b0; acc = 1'b0; ptag = 4'd0; paddr = 32'd0;
    end else if (!pend) begin
      if (proc2Icache_req && !m_rhit) begin pend = 1'b1; acc = 1'b0; paddr = m_blk; end
    end else if (!acc) begin
      if (Imem2proc_response != 4'd0) begin acc = 1'b1; ptag = Imem2proc_response; end
      else if (proc2Icache_req && m_blk != paddr) paddr = m_blk;
    end else if (m_fill) begin
      pi = paddr[7:3];
      mv[pi] = 1'b1; mblk[pi] = paddr; mdat[pi] = Imem2proc_data;
      pend = 1'b0; acc = 1'b0; ptag = 4'd0;
    end
    @(negedge clock);
  endtask

  task automatic drain(input string nm);
    int   n = 0;
    cyc_t c;
    while (pend && n < 20) begin
      c = cy(paddr, 1'b1, acc ? 4'd0 : 4'd1, acc ? ptag : 4'd0, acc ? memdata(paddr) : 64'd0);
      drive(c);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL %s_drain[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 nm, n, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      tick();
      n++;
    end
    tests++;
    if (pend) begin
      fails++;
      $display("FAIL %s_drain: miss still outstanding after %0d cycles, want idle", nm, n);
    end
  endtask

  task automatic test_reset();
    drive(cy(32'h0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1));
    tick();
    drive(cy(32'h0, 1'b0, 4'd0, 4'd0, 64'd0));
    tests++;
    if (obs !== 99'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want all zero", obs);
    end
    tick();
  endtask

  task automatic test_cold_miss();
    cyc_t        s[$];
    logic [63:0] d = 64'hDEADBEEF_00112233;
    s.push_back(cy(32'h100, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h100, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h100, 1'b1, 4'd3, 4'd0, 64'd0));
    for (int k = 0; k < 9; k++) s.push_back(cy(32'h100, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h100, 1'b1, 4'd0, 4'd3, d));
    s.push_back(cy(32'h104, 1'b1, 4'd0, 4'd0, 64'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL cold_miss[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 i, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      if (i == 1 || i == 12 || i == 13) begin
        tests++;
        if ((i == 1 && (proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h100)) ||
            (i >= 12 && (Icache_valid_out !== 1'b1 || Icache_data_out !== d))) begin
          fails++;
          $display("FAIL cold_miss_const[%0d]: got v=%0b d=%h cmd=%0d addr=%h", i,
                   Icache_valid_out, Icache_data_out, proc2Imem_command, proc2Imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    cyc_t        s[$];
    logic [63:0] d2 = 64'h0202_0202_ABCD_0200;
    s.push_back(cy(32'h200, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h200, 1'b1, 4'd2, 4'd0, 64'd0));
    s.push_back(cy(32'h200, 1'b1, 4'd0, 4'd2, d2));
    s.push_back(cy(32'h200, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h100, 1'b1, 4'd0, 4'd0, 64'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL conflict[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 i, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      if (i == 0 || i == 3 || i == 4) begin
        tests++;
        if (Icache_valid_out !== (i == 3) || (i == 3 && Icache_data_out !== d2)) begin
          fails++;
          $display("FAIL conflict_const[%0d]: got v=%0b d=%h, want v=%0b", i, Icache_valid_out,
                   Icache_data_out, (i == 3));
        end
      end
      tick();
    end
    drain("conflict");
  endtask

  task automatic test_retarget();
    cyc_t        s[$];
    logic [63:0] d4 = 64'h4444_0000_4444_0400;
    s.push_back(cy(32'h300, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h300, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h300, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h400, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h400, 1'b1, 4'd6, 4'd0, 64'd0));
    s.push_back(cy(32'h400, 1'b1, 4'd0, 4'd6, d4));
    s.push_back(cy(32'h404, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h300, 1'b1, 4'd0, 4'd0, 64'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL retarget[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 i, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      if (i == 3 || i == 4 || i == 7) begin
        tests++;
        if ((i == 3 && proc2Imem_addr !== 32'h300) || (i == 4 && proc2Imem_addr !== 32'h400) ||
            (i == 7 && Icache_valid_out !== 1'b0)) begin
          fails++;
          $display("FAIL retarget_const[%0d]: got v=%0b addr=%h", i, Icache_valid_out, proc2Imem_addr);
        end
      end
      tick();
    end
    drain("retarget");
  endtask

  task automatic test_squash_and_wrong_tag();
    cyc_t        s[$];
    logic [63:0] d5 = 64'h5555_0500_5555_0500;
    logic [63:0] d7 = 64'h7777_0700_7777_0700;
    s.push_back(cy(32'h500, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h500, 1'b1, 4'd5, 4'd0, 64'd0));
    s.push_back(cy(32'h600, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h600, 1'b1, 4'd0, 4'd5, d5));
    s.push_back(cy(32'h600, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h500, 1'b1, 4'd4, 4'd0, 64'd0));
    s.push_back(cy(32'h500, 1'b1, 4'd0, 4'd4, memdata(32'h600)));
    s.push_back(cy(32'h700, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h700, 1'b1, 4'd5, 4'd0, 64'd0));
    s.push_back(cy(32'h700, 1'b1, 4'd0, 4'd2, 64'hBAD2));
    s.push_back(cy(32'h700, 1'b1, 4'd0, 4'd7, 64'hBAD7));
    s.push_back(cy(32'h700, 1'b1, 4'd0, 4'd5, d7));
    foreach (s[i]) begin
      drive(s[i]);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL squash[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 i, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      if (i == 3 || i == 5 || i == 9 || i == 10 || i == 11) begin
        tests++;
        if (((i == 3 || i == 9 || i == 10) && Icache_valid_out !== 1'b0) ||
            (i == 5 && (Icache_valid_out !== 1'b1 || Icache_data_out !== d5 ||
                        proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h600)) ||
            (i == 11 && (Icache_valid_out !== 1'b1 || Icache_data_out !== d7))) begin
          fails++;
          $display("FAIL squash_const[%0d]: got v=%0b d=%h cmd=%0d addr=%h", i,
                   Icache_valid_out, Icache_data_out, proc2Imem_command, proc2Imem_addr);
        end
      end
      tick();
    end
    drain("squash");
  endtask

  task automatic test_reset_mid_wait();
    cyc_t s[$];
    s.push_back(cy(32'h108, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h108, 1'b1, 4'd9, 4'd0, 64'd0));
    s.push_back(cy(32'h108, 1'b1, 4'd0, 4'd0, 64'd0));
    s.push_back(cy(32'h108, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1));
    s.push_back(cy(32'h108, 1'b0, 4'd0, 4'd9, 64'h9999));
    s.push_back(cy(32'h100, 1'b1, 4'd0, 4'd9, 64'h9999));
    s.push_back(cy(32'h108, 1'b1, 4'd0, 4'd0, 64'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL reset_wait[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 i, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      if (i >= 4) begin
        tests++;
        if ((i == 4 && obs !== 99'd0) || (i > 4 && Icache_valid_out !== 1'b0)) begin
          fails++;
          $display("FAIL reset_wait_const[%0d]: got v=%0b cmd=%0d addr=%h", i,
                   Icache_valid_out, proc2Imem_command, proc2Imem_addr);
        end
      end
      tick();
    end
    drain("reset_wait");
  endtask

  task automatic test_random();
    cyc_t c;
    int   cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      c = cy(($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7),
             ($urandom % 5) != 0, 4'd0, 4'd0, 64'd0, ($urandom % 200) == 0);
      if (pend && !acc) begin
        if ($urandom % 3 == 0) begin
          c.resp = 4'($urandom_range(1, 15));
          cnt = $urandom_range(0, 5);
        end
      end else if (pend && acc) begin
        if (cnt == 0) begin
          c.rt = ptag; c.rd = memdata(paddr);
        end else begin
          cnt--;
          if ($urandom % 4 == 0) begin
            c.rt = ptag ^ 4'($urandom_range(1, 15)); c.rd = {$urandom, $urandom};
          end
        end
      end else if ($urandom % 8 == 0) begin
        c.rt = 4'($urandom_range(1, 15)); c.rd = {$urandom, $urandom};
      end
      drive(c);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL random[%0d]: got v=%0b d=%h cmd=%0d addr=%h, want v=%0b d=%h cmd=%0d addr=%h",
                 n, obs[98], obs[97:34], obs[33:32], obs[31:0], expv[98], expv[97:34], expv[33:32], expv[31:0]);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_cold_miss();
    test_conflict();
    test_retarget();
    test_squash_and_wrong_tag();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
